// File: rtl/mem_stage_buf.sv
// mem_stage_buf -- in-order memory stage between execute and writeback.
//
// Tracks up to DEPTH instructions in a circular buffer so several loads and
// stores can be outstanding on the data port at once. Non-memory ops and
// faulting memory ops are enqueued already complete. Legal memory ops issue
// a request on acceptance and complete when their in-order response returns.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   in_valid/in_ready        execute -> stage handshake
//   in_load/in_store/in_funct3/in_addr/in_wdata   memory op description
//   in_rd_addr/in_rd_data/in_we                   non-memory writeback
//   dmem_req/dmem_ready      request handshake to the data port
//   dmem_addr/rmask/wmask/wdata                   lane-aligned request
//   dmem_resp/dmem_rdata     in-order response, one per accepted request
//   out_valid/out_ready      head entry -> writeback handshake
//   out_rd_addr/out_rd_data/out_we/out_mem_rdata/out_exc  head entry
//   resp_err                 sticky: response arrived with nothing pending
module mem_stage_buf #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_load,
    input  logic                in_store,
    input  logic [2:0]          in_funct3,
    input  logic [XLEN-1:0]     in_addr,
    input  logic [XLEN-1:0]     in_wdata,
    input  logic [4:0]          in_rd_addr,
    input  logic [XLEN-1:0]     in_rd_data,
    input  logic                in_we,
    output logic                dmem_req,
    input  logic                dmem_ready,
    output logic [XLEN-1:0]     dmem_addr,
    output logic [XLEN/8-1:0]   dmem_rmask,
    output logic [XLEN/8-1:0]   dmem_wmask,
    output logic [XLEN-1:0]     dmem_wdata,
    input  logic                dmem_resp,
    input  logic [XLEN-1:0]     dmem_rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4:0]          out_rd_addr,
    output logic [XLEN-1:0]     out_rd_data,
    output logic                out_we,
    output logic [XLEN-1:0]     out_mem_rdata,
    output logic                out_exc,
    output logic                resp_err
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int PTRW = $clog2(DEPTH);

    typedef struct packed {
        logic            done;
        logic            exc;
        logic            we;
        logic            mem;     // issued a request, expects a response
        logic            load;
        logic [4:0]      rd_addr;
        logic [2:0]      funct3;
        logic [OFFW-1:0] offset;
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] raw;
    } entry_t;

    entry_t          ent [DEPTH];
    logic [PTRW-1:0] head, tail, pend;
    logic [PTRW:0]   count;
    logic            pend_vld;

    // ---------------- request decode ----------------
    logic [OFFW-1:0] offset;
    logic            mem_op, legal, aligned, mem_ok, has_room, enq, deq;
    logic [NB-1:0]   lane_base, lane_mask;

    assign offset = in_addr[OFFW-1:0];
    assign mem_op = in_load | in_store;

    always_comb begin
        legal = 1'b0;
        if (in_load) begin
            case (in_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
                3'b011, 3'b110:                         legal = (XLEN == 64);
                default:                                legal = 1'b0;
            endcase
        end else if (in_store) begin
            case (in_funct3)
                3'b000, 3'b001, 3'b010: legal = 1'b1;
                3'b011:                 legal = (XLEN == 64);
                default:                legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        aligned   = 1'b1;
        lane_base = '0;
        case (in_funct3[1:0])
            2'b00: begin lane_base = NB'(1);  aligned = 1'b1;              end
            2'b01: begin lane_base = NB'(3);  aligned = ~offset[0];        end
            2'b10: begin lane_base = NB'(15); aligned = (offset[1:0] == 2'b00); end
            default: begin lane_base = '1;    aligned = (offset == '0);   end
        endcase
    end

    assign mem_ok    = mem_op & legal & aligned;
    assign lane_mask = lane_base << offset;
    assign has_room  = (count < (PTRW+1)'(DEPTH));

    // rst gates the handshakes so nothing is offered or accepted in reset.
    assign in_ready   = rst & has_room & (~mem_ok | dmem_ready);
    assign dmem_req   = rst & in_valid & mem_ok & has_room;
    assign dmem_addr  = {in_addr[XLEN-1:OFFW], OFFW'(0)};
    assign dmem_rmask = (in_load  & mem_ok) ? lane_mask : '0;
    assign dmem_wmask = (in_store & mem_ok) ? lane_mask : '0;
    assign dmem_wdata = (in_store & mem_ok) ? (in_wdata << {offset, 3'b000}) : '0;

    assign enq = in_valid & in_ready;
    assign deq = out_valid & out_ready;

    entry_t new_ent;
    always_comb begin
        new_ent         = '0;
        new_ent.done    = ~mem_ok;
        new_ent.exc     = mem_op & ~mem_ok;
        new_ent.we      = mem_op ? 1'b0 : in_we;
        new_ent.mem     = mem_ok;
        new_ent.load    = in_load;
        new_ent.rd_addr = in_rd_addr;
        new_ent.funct3  = in_funct3;
        new_ent.offset  = offset;
        new_ent.data    = mem_op ? '0 : in_rd_data;
    end

    // ---------------- response matching ----------------
    // Responses are in order, so the pending entry is always the oldest live
    // entry still waiting on the port; derive it from head instead of
    // maintaining a separate pointer that could drift out of step.
    always_comb begin
        pend     = '0;
        pend_vld = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!pend_vld && ((PTRW+1)'(i) < count) &&
                ent[head + PTRW'(i)].mem && !ent[head + PTRW'(i)].done) begin
                pend     = head + PTRW'(i);
                pend_vld = 1'b1;
            end
        end
    end

    logic [XLEN-1:0] sh, ld_val;
    assign sh = dmem_rdata >> {ent[pend].offset, 3'b000};

    always_comb begin
        case (ent[pend].funct3)
            3'b000:  ld_val = XLEN'($signed(sh[7:0]));
            3'b100:  ld_val = XLEN'(sh[7:0]);
            3'b001:  ld_val = XLEN'($signed(sh[15:0]));
            3'b101:  ld_val = XLEN'(sh[15:0]);
            3'b010:  ld_val = XLEN'($signed(sh[31:0]));
            3'b110:  ld_val = XLEN'(sh[31:0]);
            default: ld_val = sh;
        endcase
    end

    // ---------------- state ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            resp_err <= 1'b0;
        end else begin
            if (enq) begin
                ent[tail] <= new_ent;
                tail      <= tail + 1'b1;
            end
            if (deq) head <= head + 1'b1;

            // pend is never tail while a slot is free, so this cannot
            // collide with the enqueue write above.
            if (dmem_resp) begin
                if (pend_vld) begin
                    ent[pend].done <= 1'b1;
                    if (ent[pend].load) begin
                        ent[pend].data <= ld_val;
                        ent[pend].raw  <= dmem_rdata;
                        ent[pend].we   <= (ent[pend].rd_addr != 5'd0);
                    end else begin
                        ent[pend].we   <= 1'b0;
                    end
                end else begin
                    resp_err <= 1'b1;
                end
            end

            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ---------------- head outputs ----------------
    assign out_valid     = (count != '0) & ent[head].done;
    assign out_we        = out_valid & ent[head].we;
    assign out_exc       = out_valid & ent[head].exc;
    assign out_rd_addr   = ent[head].rd_addr;
    assign out_rd_data   = out_we ? ent[head].data : '0;
    assign out_mem_rdata = ent[head].raw;

endmodule
